jt89_bus_ctl: RTL
=================

# jt89_bus_ctl

Host-bus front end and register file for the JT89 PSG. It decodes the SN76489 latch/data byte protocol from a CPU write port into the three 10-bit tone periods, four 4-bit attenuations and the noise control word that drive the tone, noise and volume datapaths. It also generates the chip's READY wait-state line, holding the CPU off for a fixed number of PSG clock-enable ticks after every accepted write.

## Interface
- READY_CYCLES, 32: number of `clk_en` ticks READY stays low after an accepted write; must be ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  PSG clock enable, the same strobe fed to the tone channels.
- cs_n  in  1  chip select, active low.
- wr_n  in  1  write strobe, active low.
- din  in  8  CPU data byte.
- ready  out  1  high = idle and able to accept a write; low = busy.
- tone0, tone1, tone2  out  10 each  tone period per channel.
- vol0, vol1, vol2, vol3  out  4 each  attenuation, where 0 = loudest and F = silent; vol3 is the noise channel.
- noise_ctl  out  3  noise register: bit2 = white/periodic, bits1:0 = rate.
- noise_rst  out  1  LFSR reset request after any noise-register write.

## Operation
- Strobe: `wr_act = ~cs_n & ~wr_n`, registered once into `wr_q`. A write event is a rising edge of `wr_act` against `wr_q`, detected in clk cycle N. Holding the strobe active produces only one event.
- FSM has two states.
  - IDLE: ready = 1. On a write event, capture `din`, apply the decode, load the counter with READY_CYCLES and go to BUSY.
  - BUSY: ready = 0. Each `clk_en` decrements the counter. On the `clk_en` that takes the counter from 1 to 0, go to IDLE.
- Write events in BUSY are ignored entirely: no capture, no decode, no counter reload.
- Latched register index `lreg[2:0]` selects the target:
  - 0/2/4 = tone0/1/2
  - 1/3/5 = vol0/1/2
  - 6 = noise
  - 7 = vol3
- Latch byte (`din[7]=1`):
  - `lreg <= din[6:4]`.
  - Tone target: `tone[3:0] <= din[3:0]`; bits 9:4 are kept.
  - Vol target: `vol <= din[3:0]`.
  - Noise target: `noise_ctl <= din[2:0]` and set noise_rst.
- Data byte (`din[7]=0`), using the current `lreg`:
  - Tone target: `tone[9:4] <= din[5:0]`; `din[6]` is ignored and bits 3:0 are kept.
  - Vol target: `vol <= din[3:0]`.
  - Noise target: `noise_ctl <= din[2:0]` and set noise_rst.
- noise_rst: once set, it stays high through the first subsequent clk cycle with `clk_en=1`, inclusive, and clears on the next clk. This lets the clock-enabled noise LFSR always sample it. A new noise write while it is already high simply keeps it high.
- Counter width is `$clog2(READY_CYCLES+1)`. There is no wrap: the counter is reloaded only from IDLE.

## Timing
- Reset values: ready=1, state IDLE, counter 0, lreg=0, tone0..2=0, vol0..3=4'hF, noise_ctl=0, noise_rst=0, wr_q=0.
- Asserting rst_n mid-BUSY returns every output to its reset value immediately (asynchronous). Bus activity during reset is not captured.
- Write event in cycle N (`wr_act` high, `wr_q` low):
  - Register outputs update at the rising edge ending cycle N, i.e. visible in N+1.
  - ready is low from N+1.
  - noise_rst, if set, is high from N+1.
- ready returns high in the cycle after the READY_CYCLES-th `clk_en`-qualified cycle counted from N+1.
  - With `clk_en` tied high, ready is low for exactly READY_CYCLES cycles.
- `clk_en` coinciding with cycle N does not count toward the busy period.
- Decode does not depend on `clk_en`.
- Write event in the same cycle BUSY ends (final tick): ignored, because state is still BUSY.

## Test plan
- Reset: hold rst_n=0, then release → ready=1, tones=0, vols=F, noise_ctl=0, noise_rst=0.
- Tone write, `clk_en`=1 continuously, READY_CYCLES=32:
  - Write 0x8E, then after ready rises write 0x0F → tone0=10'h0FE, lreg=0, other registers unchanged.
  - ready is low for exactly 32 cycles after each write.
- Volume/noise with `clk_en` every 4th clk:
  - Write 0xD5 → vol2=5.
  - Write 0xE6 → noise_ctl=3'b110, and noise_rst is high until and including the next `clk_en` cycle.
  - Write 0x07 (data byte, lreg=6) → noise_ctl=3'b111 and noise_rst pulses again.
  - Each busy period spans 32 `clk_en` ticks (≈128 clks).
- Write during BUSY: write 0x81, then 3 cycles later write 0x3F → second byte ignored; tone0[9:4] unchanged and the busy period is not extended.
- Held strobe: keep cs_n=wr_n=0 for 100 cycles with din=0x9A → exactly one write (vol0=A); ready returns high after 32 cycles while the strobe is still held, with no second write.
- Async reset in BUSY: assert rst_n 10 cycles into BUSY → ready=1 and all registers return to reset values in the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/jt89_bus_ctl.sv
// JT89 host-bus front end: SN76489 latch/data byte decode into the tone, volume
// and noise registers, plus the READY wait-state generator.
module jt89_bus_ctl #(
  parameter int unsigned READY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] noise_ctl,
  output logic       noise_rst
);

  localparam int unsigned CW = $clog2(READY_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      lreg;
  logic            wr_q;
  logic            wr_act;
  logic            wr_evt;
  logic [2:0]      tgt;
  logic [2:0][9:0] tone_r;
  logic [3:0][3:0] vol_r;

  always_comb begin
    wr_act = ~cs_n & ~wr_n;
    wr_evt = wr_act & ~wr_q;
    tgt    = din[7] ? din[6:4] : lreg;
  end

  // Register index layout: even indices below 6 are tones, odd ones volumes,
  // so bits [2:1] select the channel in both banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      cnt       <= '0;
      lreg      <= '0;
      wr_q      <= 1'b0;
      tone_r    <= '0;
      vol_r     <= '1;
      noise_ctl <= '0;
      noise_rst <= 1'b0;
    end else begin
      wr_q <= wr_act;
      // Held until the LFSR has seen one enabled cycle; a new noise write below wins.
      if (noise_rst && clk_en)
        noise_rst <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_evt) begin
            if (din[7])
              lreg <= din[6:4];
            unique case (tgt)
              3'd0, 3'd2, 3'd4: begin
                if (din[7])
                  tone_r[tgt[2:1]][3:0] <= din[3:0];
                else
                  tone_r[tgt[2:1]][9:4] <= din[5:0];
              end
              3'd6: begin
                noise_ctl <= din[2:0];
                noise_rst <= 1'b1;
              end
              default: vol_r[tgt[2:1]] <= din[3:0];
            endcase
            cnt   <= CW'(READY_CYCLES);
            state <= BUSY;
            ready <= 1'b0;
          end
        end
        BUSY: begin
          if (clk_en) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= IDLE;
              ready <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    tone0 = tone_r[0];
    tone1 = tone_r[1];
    tone2 = tone_r[2];
    vol0  = vol_r[0];
    vol1  = vol_r[1];
    vol2  = vol_r[2];
    vol3  = vol_r[3];
  end

endmodule
